// File: rtl/ysyx_23060077_shift_div_pkg.sv
// Shared types and default sizes for the radix-2 restoring divider.
// Optional early-out path: YSYX_23060077_DIV_FAST_EN (see top module).
package ysyx_23060077_shift_div_pkg;

  localparam int unsigned DivWidth = 32;
  localparam int unsigned DivCntW  = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/ysyx_23060077_div_step.sv
// One restoring division step: shift in the next dividend bit and subtract the
// divisor when the shifted partial remainder is large enough.
module ysyx_23060077_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] d,
  input  logic             bit_in,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);

  // One extra bit: the shifted remainder can reach 2*d-1, which exceeds WIDTH bits.
  logic [WIDTH:0] shifted;

  always_comb begin
    shifted = {r_in, bit_in};
    q_bit   = (shifted >= {1'b0, d});
    // When q_bit is set the true difference is below d, so it fits in WIDTH bits.
    r_out   = q_bit ? (shifted[WIDTH-1:0] - d) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/ysyx_23060077_shift_div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one restoring step per cycle.
// Define YSYX_23060077_DIV_FAST_EN to finish trivial cases (d==0, |d|>|n|) early.
module ysyx_23060077_shift_div
  import ysyx_23060077_shift_div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth,
  parameter int unsigned CNT_W = DivCntW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic             accept;
  logic             dvd_neg, dsr_neg, dsr_zero;
  logic [WIDTH-1:0] dvd_abs, dsr_abs;
  logic             fast_path;
  logic             calc_last;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  // A flush in the same cycle as a request drops the request.
  assign accept = div_valid & div_ready & ~flush;

  // Magnitude of 0x8000_0000 is 2^31 as an unsigned value; no saturation needed.
  always_comb begin
    dvd_neg  = div_signed & dividend[WIDTH-1];
    dsr_neg  = div_signed & divisor[WIDTH-1];
    dsr_zero = (divisor == '0);
    dvd_abs  = dvd_neg ? (~dividend + 1'b1) : dividend;
    dsr_abs  = dsr_neg ? (~divisor + 1'b1) : divisor;
  end

`ifdef YSYX_23060077_DIV_FAST_EN
  assign fast_path = dsr_zero | (dsr_abs > dvd_abs);
`else
  assign fast_path = 1'b0;
`endif

  // cnt reaching WIDTH means all steps are done; the next CALC cycle applies signs.
  assign calc_last = (cnt_q == CNT_W'(WIDTH));

  ysyx_23060077_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .r_in   (rem_q),
    .d      (dsr_q),
    .bit_in (dvd_q[WIDTH-1]),
    .r_out  (step_rem),
    .q_bit  (step_q)
  );

  // FSM: state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept)    state_d = StCalc;
      StCalc: if (calc_last) state_d = StDone;
      StDone:                state_d = StIdle;
      default:               state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
    end
  end

  // FSM: outputs.
  always_comb begin
    div_ready = (state_q == StIdle);
    out_valid = (state_q == StDone) & ~flush;
  end

  // Datapath next state.
  always_comb begin
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    if (accept) begin
      dvd_d   = dvd_abs;
      dsr_d   = dsr_abs;
      q_neg_d = (dvd_neg ^ dsr_neg) & ~dsr_zero;
      r_neg_d = dvd_neg;
      if (fast_path) begin
        // Preload the final magnitudes and skip straight to the sign-fix cycle.
        cnt_d = CNT_W'(WIDTH);
        rem_d = dvd_abs;
        quo_d = dsr_zero ? '1 : '0;
      end else begin
        cnt_d = '0;
        rem_d = '0;
        quo_d = '0;
      end
    end else if ((state_q == StCalc) && !flush) begin
      if (calc_last) begin
        quotient_d  = q_neg_q ? (~quo_q + 1'b1) : quo_q;
        remainder_d = r_neg_q ? (~rem_q + 1'b1) : rem_q;
      end else begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
